dtw_frame_loader: RTL and testbench

- Host-side sequencer for the DTW core. Drives the core's data/address/status/enable inputs and reads back its state and result outputs.
- Accepts feature words on a valid/ready stream in a fixed order: template frames first, then test frames.
- After loading, it starts the computation, waits for the core's done state, and captures the DTW distance.
- Returns the distance on a result valid/ready handshake, with timeout protection.

---
 rtl/dtw_frame_loader_if.sv | 42 ++++
 rtl/dtw_frame_loader.sv | 141 ++++++++++++++
 tb/tb_dtw_frame_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_frame_loader_if.sv
// Bundle of handshake and bus signals between the DTW frame loader, its host and the DTW core.
// Latency: none (wires only).
// Backpressure: s_valid/s_ready on the feature stream, res_valid/res_ready on the result.
// Ports (slave = loader view):
//   start, cfg_len                    run request and frames-per-sequence minus 1
//   s_data, s_valid, s_ready          feature word stream, templates first, then tests
//   data_in, data_addr, sys_status,   core write word, frame address, command
//   en                                core enable
//   dtw_state_in, dtw_in              core state code and distance result
//   res_data, res_valid, res_ready    captured distance handshake
//   busy, error                       status: not idle, sticky timeout
interface dtw_frame_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] cfg_len;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] data_addr;
  logic [1:0]        sys_status;
  logic              en;
  logic [3:0]        dtw_state_in;
  logic [DATA_W-1:0] dtw_in;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              error;

  modport slave (
    input  start, cfg_len, s_data, s_valid, dtw_state_in, dtw_in, res_ready,
    output s_ready, data_in, data_addr, sys_status, en, res_data, res_valid, busy, error
  );

  modport master (
    output start, cfg_len, s_data, s_valid, dtw_state_in, dtw_in, res_ready,
    input  s_ready, data_in, data_addr, sys_status, en, res_data, res_valid, busy, error
  );
endinterface

// File: rtl/dtw_frame_loader.sv
// Host-side sequencer for the DTW core: loads template then test frames, runs the core, returns the distance.
// Latency: accepted beat -> core write strobe 1 cycle; armed done state -> res_valid 1 cycle.
// Backpressure: s_ready high only while loading; res_valid/res_data hold until res_ready.
// Ports: clk, rst (synchronous, active high); bus (dtw_frame_loader_if.slave) carries the
//   feature stream, core command/data/state signals, result handshake and busy/error status.
module dtw_frame_loader #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 8,
  parameter logic [3:0]  DONE_STATE = 4'b1001,
  parameter int          TIMEOUT    = 1000000
) (
  input logic               clk,
  input logic               rst,
  dtw_frame_loader_if.slave bus
);

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_TEMP = 2'b01;
  localparam logic [1:0] ST_TEST = 2'b10;
  localparam logic [1:0] ST_COMP = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TEMP,
    LOAD_TEST,
    WAIT_DONE,
    RESULT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic              arm;
  logic [TCNT_W-1:0] tcnt;
  logic              beat;

  // s_ready is itself a register, so the handshake is qualified by the registered value.
  assign beat = bus.s_valid && bus.s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= '0;
      idx            <= '0;
      arm            <= 1'b0;
      tcnt           <= '0;
      bus.s_ready    <= 1'b0;
      bus.data_in    <= '0;
      bus.data_addr  <= '0;
      bus.sys_status <= ST_IDLE;
      bus.en         <= 1'b0;
      bus.res_data   <= '0;
      bus.res_valid  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.sys_status <= ST_IDLE;
          bus.en         <= 1'b0;
          bus.s_ready    <= 1'b0;
          if (bus.start) begin
            len_q       <= bus.cfg_len;
            idx         <= '0;
            bus.error   <= 1'b0;
            bus.s_ready <= 1'b1;
            bus.en      <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= LOAD_TEMP;
          end
        end

        LOAD_TEMP, LOAD_TEST: begin
          // Write strobe is a one-cycle pulse; address and data hold between beats.
          bus.sys_status <= ST_IDLE;
          if (beat) begin
            bus.data_in    <= bus.s_data;
            bus.data_addr  <= idx;
            bus.sys_status <= (state == LOAD_TEMP) ? ST_TEMP : ST_TEST;
            if (idx == len_q) begin
              idx <= '0;
              if (state == LOAD_TEMP) begin
                state <= LOAD_TEST;
              end else begin
                bus.s_ready <= 1'b0;
                arm         <= 1'b0;
                tcnt        <= '0;
                state       <= WAIT_DONE;
              end
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end

        WAIT_DONE: begin
          bus.sys_status <= ST_COMP;
          bus.en         <= 1'b1;
          // A done code seen before the core ever left it is stale from an earlier run.
          if (bus.dtw_state_in != DONE_STATE) begin
            arm <= 1'b1;
          end
          if (arm && (bus.dtw_state_in == DONE_STATE)) begin
            bus.res_data   <= bus.dtw_in;
            bus.res_valid  <= 1'b1;
            bus.sys_status <= ST_IDLE;
            bus.en         <= 1'b0;
            state          <= RESULT;
          end else if (tcnt == TCNT_LAST) begin
            bus.res_data   <= '1;
            bus.res_valid  <= 1'b1;
            bus.error      <= 1'b1;
            bus.sys_status <= ST_IDLE;
            bus.en         <= 1'b0;
            state          <= RESULT;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        RESULT: begin
          bus.sys_status <= ST_IDLE;
          bus.en         <= 1'b0;
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_frame_loader.sv
module tb_dtw_frame_loader;

  localparam int         DATA_W = 32;
  localparam int         ADDR_W = 8;
  localparam int         TMO    = 50;
  localparam logic [3:0] DONE   = 4'b1001;
  localparam int         M_NORM  = 0;
  localparam int         M_STALE = 1;
  localparam int         M_HANG  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtw_frame_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dtw_frame_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DONE_STATE(DONE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s_ready"},    bus.s_ready, 0);
    check({tag, "_data_in"},    bus.data_in, 0);
    check({tag, "_data_addr"},  bus.data_addr, 0);
    check({tag, "_sys_status"}, bus.sys_status, 0);
    check({tag, "_en"},         bus.en, 0);
    check({tag, "_res_data"},   bus.res_data, 0);
    check({tag, "_res_valid"},  bus.res_valid, 0);
    check({tag, "_busy"},       bus.busy, 0);
    check({tag, "_error"},      bus.error, 0);
  endtask

  task automatic drive_idle();
    bus.start        = 1'b0;
    bus.cfg_len      = '0;
    bus.s_data       = '0;
    bus.s_valid      = 1'b0;
    bus.dtw_state_in = 4'b0000;
    bus.dtw_in       = '0;
    bus.res_ready    = 1'b0;
  endtask

  // Core behaviour as a function of cycles already spent waiting for the result.
  function automatic logic [3:0] core_state(input int mode, input int w, input int d);
    case (mode)
      M_NORM:  return (w >= d) ? DONE : 4'b0010;
      M_STALE: return (w == 0 || w >= 6) ? DONE : 4'b0010;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic run(input int len, input int gap_pct, input int mode, input int done_after,
                     input int rdy_delay, input int abort_at, input bit fixed_words,
                     input logic [31:0] result);
    logic [31:0] words[$];
    logic [31:0] exp_val, din;
    logic [3:0]  st;
    int total, k, wcnt, cyc, nwr, hcnt, due_cyc, budget, b;
    bit acc, decided, seen_nd, got_res, fin, err_exp, exp_err, vld, rdy, timed_out;

    total = 2 * (len + 1);
    k = 0; wcnt = 0; cyc = 0; nwr = 0; hcnt = 0; due_cyc = -1; b = 0;
    acc = 0; decided = 0; seen_nd = 0; got_res = 0; fin = 0;
    err_exp = 0; exp_err = 0; timed_out = 0; exp_val = '0; vld = 0; rdy = 0;
    budget = 20 * total + 4 * TMO + rdy_delay + 100;
    words.delete();
    for (int i = 0; i < total; i++) begin
      if (fixed_words) words.push_back((i <= len) ? 32'h11 + 32'(i) : 32'h21 + 32'(i - len - 1));
      else             words.push_back($urandom);
    end

    check("idle_busy", bus.busy, 0);
    check("idle_error_sticky", bus.error, last_err);

    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.cfg_len = ADDR_W'(len);
    @(posedge clk); #1;

    while (1) begin
      // Inputs for this cycle.
      if (k < total) begin
        vld = ($urandom_range(99) >= gap_pct);
        bus.s_data = vld ? words[k] : $urandom;
        st = (mode == M_STALE) ? DONE : 4'b0000;
      end else begin
        vld = 1'b0;
        bus.s_data = $urandom;
        st = core_state(mode, wcnt, done_after);
      end
      bus.s_valid      = vld;
      din              = (mode == M_STALE && wcnt < 6) ? 32'hDEAD_BEEF : result;
      bus.dtw_state_in = st;
      bus.dtw_in       = din;
      bus.start        = !fin && ($urandom_range(7) == 0);
      bus.cfg_len      = ADDR_W'($urandom);
      rdy              = got_res && !fin && (hcnt >= rdy_delay);
      bus.res_ready    = rdy;

      @(negedge clk);
      cyc++;
      if (fin) begin
        check("end_res_valid", bus.res_valid, 0);
        check("end_busy", bus.busy, 0);
        check("end_en", bus.en, 0);
        check("end_status", bus.sys_status, 0);
        check("end_error", bus.error, err_exp);
        last_err = err_exp;
        break;
      end
      if (cyc == due_cyc) begin
        got_res = 1'b1;
        err_exp = exp_err;
      end
      check("error", bus.error, err_exp);

      if (acc) begin
        b = k - 1;
        nwr++;
        check("wr_status", bus.sys_status, (b <= len) ? 1 : 2);
        check("wr_addr", bus.data_addr, b % (len + 1));
        check("wr_data", bus.data_in, words[b]);
      end else if (k < total) begin
        check("gap_status", bus.sys_status, 0);
      end

      if (k < total) begin
        check("load_s_ready", bus.s_ready, 1);
        check("load_en", bus.en, 1);
        check("load_busy", bus.busy, 1);
        check("load_res_valid", bus.res_valid, 0);
      end else if (!got_res) begin
        check("early_res", bus.res_valid, 0);
        check("wait_s_ready", bus.s_ready, 0);
        check("wait_busy", bus.busy, 1);
        if (!acc) begin
          check("compute_status", bus.sys_status, 3);
          check("compute_en", bus.en, 1);
        end
      end else begin
        check("res_valid", bus.res_valid, 1);
        check("res_data", bus.res_data, exp_val);
        check("res_status", bus.sys_status, 0);
        check("res_en", bus.en, 0);
        check("res_busy", bus.busy, 1);
        hcnt++;
        if (rdy) fin = 1'b1;
      end

      // What the loader should conclude from this cycle's core inputs.
      if (k == total && !decided) begin
        wcnt++;
        if (seen_nd && st == DONE) begin
          decided = 1'b1; due_cyc = cyc + 1; exp_val = din; exp_err = 1'b0;
        end else if (wcnt == TMO) begin
          decided = 1'b1; due_cyc = cyc + 1; exp_val = '1; exp_err = 1'b1;
        end
        if (st != DONE) seen_nd = 1'b1;
      end
      acc = (k < total) && vld;

      if (cyc > budget) begin
        check("run_budget", 0, 1);
        timed_out = 1'b1;
        break;
      end

      @(posedge clk); #1;
      if (acc) k++;
      if (abort_at > 0 && k == abort_at) begin
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("abort");
        last_err = 1'b0;
        return;
      end
    end

    if (timed_out) begin
      rst = 1'b1;
      drive_idle();
      @(posedge clk); #1;
      rst = 1'b0;
      last_err = 1'b0;
    end else begin
      check("write_count", nwr, total);
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Nominal directed run.
    run(3, 0, M_NORM, 20, 0, -1, 1'b1, 32'h0000_00A5);
    // Gappy stream with a slow result consumer.
    run(7, 50, M_NORM, $urandom_range(40, 1), 3, -1, 1'b0, $urandom);
    for (int r = 0; r < 4; r++)
      run($urandom_range(15), 40, M_NORM, $urandom_range(40, 1), $urandom_range(4), -1, 1'b0, $urandom);
    // Stale done left over on entry.
    run(2, 30, M_STALE, 0, 0, -1, 1'b0, 32'h1234_5678);
    // Timeout, then error must clear on the next start.
    run(1, 0, M_HANG, 0, 2, -1, 1'b0, 32'h0BAD_0BAD);
    run(2, 20, M_NORM, 5, 0, -1, 1'b0, $urandom);
    // Done on the very cycle the timeout would fire.
    run(0, 0, M_NORM, TMO - 1, 0, -1, 1'b0, 32'h0000_7777);
    // Single beat per phase and held result.
    run(0, 25, M_NORM, 3, 10, -1, 1'b0, $urandom);
    // Full 256-frame sequences.
    run(255, 20, M_NORM, 10, 1, -1, 1'b0, $urandom);
    // Reset part-way into the test frames, then a clean run.
    run(5, 20, M_NORM, 10, 0, 8, 1'b0, $urandom);
    run(5, 20, M_NORM, 10, 0, -1, 1'b0, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
